ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//   Memory-side fetch engine feeding the execution control unit's instruction register.
//   - Accepts a fetch request: start address from the PC plus an instruction length code from the decoder.
//   - Reads len+1 bytes over a byte-wide request/acknowledge memory port.
//   - Assembles them into a 32-bit raw word and presents it with a valid/ready handshake for the IR write.
// PARAMETERS
//   AW        16  address width of request and memory port
//   TMO_CYC   15  cycles allowed per byte before timeout (used only with IFETCH_TIMEOUT_EN)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous, active-low reset
//   req_valid  in   1   fetch request present
//   req_ready  out  1   engine idle, request accepted when req_valid&req_ready
//   req_addr   in   AW  address of first instruction byte
//   req_len    in   2   byte count minus one (0..3 -> 1..4 bytes)
//   mem_rd     out  1   byte read strobe, held until mem_ack
//   mem_addr   out  AW  byte address, stable while mem_rd high
//   mem_ack    in   1   read data valid this cycle
//   mem_data   in   8   read byte
//   rsp_valid  out  1   raw word available
//   rsp_ready  in   1   IR write enable; transfer on rsp_valid&rsp_ready
//   rsp_raw    out  32  byte i at [8i+7:8i] (insn=[7:0], d1..d3 above); unfetched bytes zero
//   rsp_len    out  2   echo of accepted req_len
//   rsp_err    out  1   response is a timeout abort (0 when timeout disabled)
// BEHAVIOUR
//   Reset: all outputs 0 except req_ready=1; state IDLE; byte counter 0.
//   FSM states:
//   - IDLE: req_ready=1. On accept, latch addr/len, clear raw, counter=0 -> RD.
//   - RD: mem_rd=1, mem_addr=base+counter (mod 2^AW, wraps FFFF->0000).
//     - On mem_ack: store mem_data into byte[counter].
//     - If counter==len -> RSP, else counter++ and stay in RD.
//     - mem_rd stays high across back-to-back bytes.
//   - RSP: rsp_valid=1, outputs stable. On rsp_ready -> IDLE (req_ready=1 next cycle).
//   Latency: accept in cycle 0; first mem_rd in cycle 1; rsp_valid the cycle after the last ack.
//     Minimum request-to-response latency = len+2 cycles with zero-wait memory.
//   Handshake rules:
//   - req_ready is low in RD and RSP; a request cannot be accepted in the same cycle as a response
//     transfer (no bypass).
//   - req_addr and req_len are sampled only at accept.
//   - mem_ack while mem_rd=0 is ignored.
//   - rsp_valid, once high, stays high with unchanged data until rsp_ready.
//   Reset mid-operation: state returns to IDLE immediately and asynchronously. mem_rd drops with no
//   further strobe; a late mem_ack is ignored.
// CONFIGURATION
//   IFETCH_TIMEOUT_EN defined:
//   - A 4-bit counter runs while in RD and clears on each ack.
//   - Reaching TMO_CYC with no ack drops mem_rd and moves to RSP with rsp_err=1.
//   - rsp_raw holds the bytes fetched so far.
//   IFETCH_TIMEOUT_EN undefined:
//   - RD waits indefinitely for mem_ack; rsp_err is tied 0; no timeout counter is built.
// STRUCTURE
//   Shared package/header ifetch_defs:
//   - state encoding (IDLE=2'd0, RD=2'd1, RSP=2'd2)
//   - LEN_BYTES(len) macro
//   - RAW_W=32 constant
//   - the byte-lane ordering used by the IR
//   Sub-module: ifetch_asm — byte-lane assembler with clear, lane select and write enable, 32-bit
//   output register. FSM, address generation and timeout stay in the top.
// TESTING
//   1. req addr=0x0100 len=0, zero-wait mem returns 0xA5 -> mem_addr 0x0100; rsp_raw=0x000000A5,
//      rsp_len=0, rsp_valid 2 cycles after accept.
//   2. addr=0x2000 len=3, bytes 11,22,33,44 -> addrs 2000..2003 in order; rsp_raw=0x44332211.
//   3. addr=0xFFFE len=3 -> mem_addr FFFE,FFFF,0000,0001 (wrap); all four bytes assembled.
//   4. rsp_ready held low 5 cycles -> rsp_valid/raw stable, req_ready=0, new req_valid ignored;
//      transfer on cycle 6, req_ready=1 next cycle.
//   5. rst asserted low during 2nd byte of len=2 fetch -> mem_rd=0, rsp_valid=0, req_ready=1 at once;
//      a later mem_ack is ignored.
//   6. IFETCH_TIMEOUT_EN, len=1, no ack for TMO_CYC=15 cycles on byte 1 -> rsp_valid with rsp_err=1,
//      rsp_raw holds byte 0 only.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch engine: state encoding, raw word
// width, IR byte-lane ordering and the LEN_BYTES helper macro.
`ifndef IFETCH_PKG_SV
`define IFETCH_PKG_SV

`define LEN_BYTES(len) ((len) + 3'd1)

package ifetch_defs;
   localparam int RAW_W     = 32;
   localparam int NUM_LANES = RAW_W / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RSP = 2'd2} state_e;

   // IR byte order: opcode byte in the low lane, displacement bytes above it
   typedef enum logic [1:0] {
      LANE_INSN = 2'd0,
      LANE_D1   = 2'd1,
      LANE_D2   = 2'd2,
      LANE_D3   = 2'd3
   } lane_e;
endpackage

`endif

// File: rtl/ifetch_asm.sv
// Byte-lane assembler: clears the raw word on a new fetch and writes one byte
// lane per accepted memory byte.
module ifetch_asm
   import ifetch_defs::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  lane_e            lane,
   input  logic [7:0]       din,
   output logic [RAW_W-1:0] raw
);
   logic [NUM_LANES-1:0][7:0] lane_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q <= '0;
      end else if (clr) begin
         lane_q <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_LANES; i++)
            if (lane == lane_e'(i)) lane_q[i] <= din;
      end
   end

   assign raw = lane_q;
endmodule

// File: rtl/ifetch.sv
// Instruction fetch engine: reads len+1 bytes over a byte-wide req/ack port and
// hands the assembled raw word to the IR. Optional per-byte timeout: IFETCH_TIMEOUT_EN.
module ifetch
   import ifetch_defs::*;
#(
   parameter int AW      = 16,
   parameter int TMO_CYC = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    req_addr,
   input  logic [1:0]       req_len,
   output logic             mem_rd,
   output logic [AW-1:0]    mem_addr,
   input  logic             mem_ack,
   input  logic [7:0]       mem_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [RAW_W-1:0] rsp_raw,
   output logic [1:0]       rsp_len,
   output logic             rsp_err
);
   state_e        state;
   logic [AW-1:0] base;
   logic [1:0]    cnt;
   logic          last;
   logic          asm_clr;
   logic          asm_we;

   assign last     = ({1'b0, cnt} + 3'd1) == `LEN_BYTES(rsp_len);
   assign asm_clr  = req_valid & req_ready;
   assign asm_we   = (state == RD) & mem_ack;
   assign mem_addr = base + AW'(cnt);

`ifdef IFETCH_TIMEOUT_EN
   logic [3:0] tmo;
   logic       tmo_hit;
   assign tmo_hit = (tmo == 4'(TMO_CYC - 1));
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         mem_rd    <= 1'b0;
         rsp_valid <= 1'b0;
         base      <= '0;
         cnt       <= '0;
         rsp_len   <= '0;
`ifdef IFETCH_TIMEOUT_EN
         rsp_err   <= 1'b0;
         tmo       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               base      <= req_addr;
               rsp_len   <= req_len;
               cnt       <= '0;
               req_ready <= 1'b0;
               mem_rd    <= 1'b1;
               state     <= RD;
`ifdef IFETCH_TIMEOUT_EN
               rsp_err   <= 1'b0;
               tmo       <= '0;
`endif
            end
            RD: begin
               if (mem_ack) begin
`ifdef IFETCH_TIMEOUT_EN
                  tmo <= '0;
`endif
                  if (last) begin
                     mem_rd    <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= RSP;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
`ifdef IFETCH_TIMEOUT_EN
               // abort keeps the bytes gathered so far in the assembler
               else if (tmo_hit) begin
                  mem_rd    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= RSP;
               end else begin
                  tmo <= tmo + 4'd1;
               end
`endif
            end
            RSP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ifetch_asm u_asm (
      .clk  (clk),
      .rst  (rst),
      .clr  (asm_clr),
      .we   (asm_we),
      .lane (lane_e'(cnt)),
      .din  (mem_data),
      .raw  (rsp_raw)
   );
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed cases plus randomized fetches against
// a byte-array memory model.
module tb_ifetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [15:0] req_addr;
   logic [1:0]  req_len;
   logic        mem_rd, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_raw;
   logic [1:0]  rsp_len;
   logic        rsp_err;

   int checks = 0;
   int passed = 0;

   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   ifetch #(.AW(16), .TMO_CYC(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_raw(rsp_raw),
      .rsp_len(rsp_len), .rsp_err(rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // reference: byte i of the word is memory[(addr+i) mod 2^16], unfetched bytes zero
   function automatic logic [31:0] exp_raw(input logic [15:0] a, input logic [1:0] l);
      logic [31:0] r;
      logic [15:0] ad;
      r = '0;
      for (int i = 0; i <= int'(l); i++) begin
         ad = a + 16'(i);
         r[8*i +: 8] = mem[ad];
      end
      return r;
   endfunction

   task automatic fetch(input logic [15:0] a, input logic [1:0] l, input int maxw, input int hold);
      logic [31:0] er;
      logic [15:0] ad;
      int          w;
      er = exp_raw(a, l);
      req_valid = 1'b1; req_addr = a; req_len = l;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0; req_addr = 16'($urandom); req_len = 2'($urandom);
      for (int i = 0; i <= int'(l); i++) begin
         ad = a + 16'(i);
         w  = $urandom_range(0, maxw);
         for (int k = 0; k < w; k++) begin
            chk("wait_mem_rd", 32'(mem_rd), 32'd1);
            chk("wait_mem_addr", 32'(mem_addr), 32'(ad));
            @(negedge clk);
         end
         chk("mem_rd", 32'(mem_rd), 32'd1);
         chk("mem_addr", 32'(mem_addr), 32'(ad));
         chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
         chk("req_ready_busy", 32'(req_ready), 32'd0);
         mem_ack = 1'b1; mem_data = mem[ad];
         @(negedge clk);
         mem_ack = 1'b0; mem_data = 8'($urandom);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_raw", rsp_raw, er);
      chk("rsp_len", 32'(rsp_len), 32'(l));
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("mem_rd_off", 32'(mem_rd), 32'd0);
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0; req_valid = 1'($urandom); req_addr = 16'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_raw", rsp_raw, er);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_mem_rd", 32'(mem_rd), 32'd0);
      end
      // request held high during transfer must not be taken (no bypass)
      rsp_ready = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
      chk("post_mem_rd", 32'(mem_rd), 32'd0);
   endtask

   initial begin
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
      mem_ack = 1'b0; mem_data = '0; rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_raw", rsp_raw, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rsp_len", 32'(rsp_len), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      mem[16'h0100] = 8'hA5;
      fetch(16'h0100, 2'd0, 0, 0);
      mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22;
      mem[16'h2002] = 8'h33; mem[16'h2003] = 8'h44;
      fetch(16'h2000, 2'd3, 0, 0);
      chk("t2_const", exp_raw(16'h2000, 2'd3), 32'h44332211);
      fetch(16'hFFFE, 2'd3, 1, 0);
      fetch(16'h1234, 2'd1, 0, 5);

      // reset during second byte of a 3-byte fetch
      req_valid = 1'b1; req_addr = 16'h3000; req_len = 2'd2;
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b1; mem_data = mem[16'h3000];
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rst_mid_addr", 32'(mem_addr), 32'h3001);
      chk("rst_mid_rd", 32'(mem_rd), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_rd", 32'(mem_rd), 32'd0);
      chk("rst_async_valid", 32'(rsp_valid), 32'd0);
      chk("rst_async_ready", 32'(req_ready), 32'd1);
      mem_ack = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ack_rd", 32'(mem_rd), 32'd0);
         chk("late_ack_valid", 32'(rsp_valid), 32'd0);
         chk("late_ack_ready", 32'(req_ready), 32'd1);
      end
      mem_ack = 1'b0;
      @(negedge clk);

`ifdef IFETCH_TIMEOUT_EN
      req_valid = 1'b1; req_addr = 16'h4000; req_len = 2'd1;
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b1; mem_data = mem[16'h4000];
      @(negedge clk);
      mem_ack = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         chk("tmo_wait_valid", 32'(rsp_valid), 32'd0);
         chk("tmo_wait_rd", 32'(mem_rd), 32'd1);
         @(negedge clk);
      end
      chk("tmo_valid", 32'(rsp_valid), 32'd1);
      chk("tmo_err", 32'(rsp_err), 32'd1);
      chk("tmo_raw", rsp_raw, {24'd0, mem[16'h4000]});
      chk("tmo_rd_off", 32'(mem_rd), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("tmo_done_ready", 32'(req_ready), 32'd1);
`endif

      for (int t = 0; t < 24; t++) begin
         a = (t % 6 == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
         fetch(a, 2'($urandom_range(0, 3)), 2, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
